// File: rtl/pzcorebus_bundled_array_if_sliced_unpacker_if.sv
// Bus configuration package and the bundled corebus interface carried by the unpacker.
// Zero-valued config fields fall back to default widths so a '0 config stays usable.
package pzcorebus_pkg;
  typedef struct packed {
    int unsigned command_width;
    int unsigned data_width;
    int unsigned response_width;
  } pzcorebus_config;

  function automatic int get_packed_command_width(pzcorebus_config cfg);
    return (cfg.command_width != 0) ? int'(cfg.command_width) : 16;
  endfunction

  // The byte-enable variant appends one strobe bit per data byte.
  function automatic int get_packed_write_data_width(pzcorebus_config cfg, int with_byte_enable);
    int dw;
    dw = (cfg.data_width != 0) ? int'(cfg.data_width) : 32;
    return (with_byte_enable != 0) ? (dw + ((dw + 7) / 8)) : dw;
  endfunction

  function automatic int get_packed_response_width(pzcorebus_config cfg);
    return (cfg.response_width != 0) ? int'(cfg.response_width) : 16;
  endfunction
endpackage

interface pzcorebus_bundled_if
  import pzcorebus_pkg::*;
#(
  parameter pzcorebus_config BUS_CONFIG        = '0,
  parameter int              REQUEST_CHANNELS  = 1,
  parameter int              RESPONSE_CHANNELS = 1
);
  localparam int COMMAND_WIDTH    = get_packed_command_width(BUS_CONFIG);
  localparam int WRITE_DATA_WIDTH = get_packed_write_data_width(BUS_CONFIG, 1);
  localparam int RESPONSE_WIDTH   = get_packed_response_width(BUS_CONFIG);

  logic [REQUEST_CHANNELS-1:0]                         mcmd_valid;
  logic [REQUEST_CHANNELS-1:0]                         scmd_accept;
  logic [REQUEST_CHANNELS-1:0][COMMAND_WIDTH-1:0]      mcmd;
  logic [REQUEST_CHANNELS-1:0]                         mdata_valid;
  logic [REQUEST_CHANNELS-1:0]                         sdata_accept;
  logic [REQUEST_CHANNELS-1:0][WRITE_DATA_WIDTH-1:0]   mdata;
  logic [RESPONSE_CHANNELS-1:0]                        sresp_valid;
  logic [RESPONSE_CHANNELS-1:0]                        mresp_accept;
  logic [RESPONSE_CHANNELS-1:0][RESPONSE_WIDTH-1:0]    sresp;

  modport master (
    output mcmd_valid, input scmd_accept, output mcmd,
    output mdata_valid, input sdata_accept, output mdata,
    input sresp_valid, output mresp_accept, input sresp
  );

  modport slave (
    input mcmd_valid, output scmd_accept, input mcmd,
    input mdata_valid, output sdata_accept, input mdata,
    output sresp_valid, input mresp_accept, output sresp
  );
endinterface

// File: rtl/pzcorebus_bundled_array_if_sliced_unpacker.sv
// Unpacks flat packed command/data/response vectors onto an array of bundled corebus
// interfaces, with an independent bypass / half / full-skid slice per bus, channel and path.
module pzcorebus_bundled_array_if_sliced_unpacker_slice #(
  parameter int STAGES = 2,
  parameter int DATA_W = 1
)(
  input  logic              clk,
  input  logic              rst,
  input  logic              up_valid,
  output logic              up_accept,
  input  logic [DATA_W-1:0] up_data,
  output logic              dn_valid,
  input  logic              dn_accept,
  output logic [DATA_W-1:0] dn_data
);
  if (STAGES == 0) begin : g_bypass
    assign up_accept = dn_accept;
    assign dn_valid  = up_valid;
    assign dn_data   = up_data;
  end else if (STAGES == 1) begin : g_half
    logic              vld_p0;
    logic [DATA_W-1:0] data_p0;
    logic              push;
    logic              pop;

    // Accept only into an empty entry, so load and drain never share a cycle.
    assign up_accept = ~vld_p0 & ~rst;
    assign dn_valid  = vld_p0 & ~rst;
    assign dn_data   = data_p0;
    assign push      = up_valid & up_accept;
    assign pop       = dn_valid & dn_accept;

    // stage p0: single holding register
    always_ff @(posedge clk) begin
      if (rst) begin
        vld_p0 <= 1'b0;
      end else if (push) begin
        vld_p0 <= 1'b1;
      end else if (pop) begin
        vld_p0 <= 1'b0;
      end
    end

    always_ff @(posedge clk) begin
      if (push) begin
        data_p0 <= up_data;
      end
    end
  end else begin : g_full
    logic [1:0]        count_p0;
    logic              wr_ptr_p0;
    logic              rd_ptr_p0;
    logic [DATA_W-1:0] data_p0 [2];
    logic              push;
    logic              pop;

    assign up_accept = (count_p0 != 2'd2) & ~rst;
    assign dn_valid  = (count_p0 != 2'd0) & ~rst;
    assign dn_data   = data_p0[rd_ptr_p0];
    assign push      = up_valid & up_accept;
    assign pop       = dn_valid & dn_accept;

    // stage p0: two-entry ring, head selected by rd_ptr
    always_ff @(posedge clk) begin
      if (rst) begin
        count_p0  <= 2'd0;
        wr_ptr_p0 <= 1'b0;
        rd_ptr_p0 <= 1'b0;
      end else begin
        count_p0 <= count_p0 + 2'(push) - 2'(pop);
        if (push) begin
          wr_ptr_p0 <= ~wr_ptr_p0;
        end
        if (pop) begin
          rd_ptr_p0 <= ~rd_ptr_p0;
        end
      end
    end

    always_ff @(posedge clk) begin
      if (push) begin
        data_p0[wr_ptr_p0] <= up_data;
      end
    end
  end
endmodule

module pzcorebus_bundled_array_if_sliced_unpacker
  import pzcorebus_pkg::*;
#(
  parameter pzcorebus_config BUS_CONFIG        = '0,
  parameter int              REQUEST_CHANNELS  = 1,
  parameter int              RESPONSE_CHANNELS = 1,
  parameter int              SIZE              = 1,
  parameter int              COMMAND_SLICE     = 2,
  parameter int              DATA_SLICE        = 2,
  parameter int              RESPONSE_SLICE    = 2,
  localparam int             COMMAND_WIDTH     = get_packed_command_width(BUS_CONFIG),
  localparam int             WRITE_DATA_WIDTH  = get_packed_write_data_width(BUS_CONFIG, 1),
  localparam int             RESPONSE_WIDTH    = get_packed_response_width(BUS_CONFIG)
)(
  input  logic                                                      i_clk,
  input  logic                                                      i_rst,
  pzcorebus_bundled_if.master                                       corebus_if [SIZE],
  output logic [SIZE-1:0][REQUEST_CHANNELS-1:0]                     o_scmd_accept,
  input  logic [SIZE-1:0][REQUEST_CHANNELS-1:0]                     i_mcmd_valid,
  input  logic [SIZE-1:0][REQUEST_CHANNELS-1:0][COMMAND_WIDTH-1:0]  i_mcmd,
  output logic [SIZE-1:0][REQUEST_CHANNELS-1:0]                     o_sdata_accept,
  input  logic [SIZE-1:0][REQUEST_CHANNELS-1:0]                     i_mdata_valid,
  input  logic [SIZE-1:0][REQUEST_CHANNELS-1:0][WRITE_DATA_WIDTH-1:0] i_mdata,
  input  logic [SIZE-1:0][RESPONSE_CHANNELS-1:0]                    i_mresp_accept,
  output logic [SIZE-1:0][RESPONSE_CHANNELS-1:0]                    o_sresp_valid,
  output logic [SIZE-1:0][RESPONSE_CHANNELS-1:0][RESPONSE_WIDTH-1:0] o_sresp
);
  if ((corebus_if[0].REQUEST_CHANNELS != REQUEST_CHANNELS) ||
      (corebus_if[0].RESPONSE_CHANNELS != RESPONSE_CHANNELS)) begin : g_channel_mismatch
    $error("corebus_if channel counts differ from unpacker channel parameters");
  end

  for (genvar i = 0; i < SIZE; i++) begin : g_bus
    logic [REQUEST_CHANNELS-1:0]                         mcmd_valid;
    logic [REQUEST_CHANNELS-1:0]                         scmd_accept;
    logic [REQUEST_CHANNELS-1:0][COMMAND_WIDTH-1:0]      mcmd;
    logic [REQUEST_CHANNELS-1:0]                         mdata_valid;
    logic [REQUEST_CHANNELS-1:0]                         sdata_accept;
    logic [REQUEST_CHANNELS-1:0][WRITE_DATA_WIDTH-1:0]   mdata;
    logic [RESPONSE_CHANNELS-1:0]                        sresp_valid;
    logic [RESPONSE_CHANNELS-1:0]                        mresp_accept;
    logic [RESPONSE_CHANNELS-1:0][RESPONSE_WIDTH-1:0]    sresp;

    assign corebus_if[i].mcmd_valid   = mcmd_valid;
    assign corebus_if[i].mcmd         = mcmd;
    assign corebus_if[i].mdata_valid  = mdata_valid;
    assign corebus_if[i].mdata        = mdata;
    assign corebus_if[i].mresp_accept = mresp_accept;
    assign scmd_accept                = corebus_if[i].scmd_accept;
    assign sdata_accept               = corebus_if[i].sdata_accept;
    assign sresp_valid                = corebus_if[i].sresp_valid;
    assign sresp                      = corebus_if[i].sresp;

    for (genvar j = 0; j < REQUEST_CHANNELS; j++) begin : g_request
      pzcorebus_bundled_array_if_sliced_unpacker_slice #(
        .STAGES (COMMAND_SLICE),
        .DATA_W (COMMAND_WIDTH)
      ) u_command_slice (
        .clk       (i_clk),
        .rst       (i_rst),
        .up_valid  (i_mcmd_valid[i][j]),
        .up_accept (o_scmd_accept[i][j]),
        .up_data   (i_mcmd[i][j]),
        .dn_valid  (mcmd_valid[j]),
        .dn_accept (scmd_accept[j]),
        .dn_data   (mcmd[j])
      );

      pzcorebus_bundled_array_if_sliced_unpacker_slice #(
        .STAGES (DATA_SLICE),
        .DATA_W (WRITE_DATA_WIDTH)
      ) u_data_slice (
        .clk       (i_clk),
        .rst       (i_rst),
        .up_valid  (i_mdata_valid[i][j]),
        .up_accept (o_sdata_accept[i][j]),
        .up_data   (i_mdata[i][j]),
        .dn_valid  (mdata_valid[j]),
        .dn_accept (sdata_accept[j]),
        .dn_data   (mdata[j])
      );
    end

    // Responses flow the other way: the bus is upstream, the packed port downstream.
    for (genvar j = 0; j < RESPONSE_CHANNELS; j++) begin : g_response
      pzcorebus_bundled_array_if_sliced_unpacker_slice #(
        .STAGES (RESPONSE_SLICE),
        .DATA_W (RESPONSE_WIDTH)
      ) u_response_slice (
        .clk       (i_clk),
        .rst       (i_rst),
        .up_valid  (sresp_valid[j]),
        .up_accept (mresp_accept[j]),
        .up_data   (sresp[j]),
        .dn_valid  (o_sresp_valid[i][j]),
        .dn_accept (i_mresp_accept[i][j]),
        .dn_data   (o_sresp[i][j])
      );
    end
  end
endmodule

// File: doc/pzcorebus_bundled_array_if_sliced_unpacker.md
PZCOREBUS_BUNDLED_ARRAY_IF_SLICED_UNPACKER -- requirements
Module: pzcorebus_bundled_array_if_sliced_unpacker

Interface
REQ-001 SHALL have parameter BUS_CONFIG, default '0: pzcorebus_config giving packed widths.
REQ-002 SHALL have parameter REQUEST_CHANNELS, default 1: request channels per bus.
REQ-003 SHALL have parameter RESPONSE_CHANNELS, default 1: response channels per bus.
REQ-004 SHALL have parameter SIZE, default 1: number of bundled buses.
REQ-005 SHALL have parameter COMMAND_SLICE, default 2: 0 = bypass, 1 = half slice (1 entry), 2 = full skid slice (2 entries).
REQ-006 SHALL have parameter DATA_SLICE, default 2, and RESPONSE_SLICE, default 2, same encoding as COMMAND_SLICE.
REQ-007 SHALL derive localparams COMMAND_WIDTH = get_packed_command_width(BUS_CONFIG), WRITE_DATA_WIDTH = get_packed_write_data_width(BUS_CONFIG, 1), RESPONSE_WIDTH = get_packed_response_width(BUS_CONFIG).
REQ-008 i_clk  input  1  sole clock; all state on rising edge.
REQ-009 i_rst  input  1  synchronous, active-high reset.
REQ-010 corebus_if  pzcorebus_bundled_if.master  [SIZE]  unpacked bus array.
REQ-011 o_scmd_accept  output  [SIZE][REQUEST_CHANNELS]  command accept per channel.
REQ-012 i_mcmd_valid  input  [SIZE][REQUEST_CHANNELS]; i_mcmd  input  [SIZE][REQUEST_CHANNELS][COMMAND_WIDTH]  packed command.
REQ-013 o_sdata_accept  output  [SIZE][REQUEST_CHANNELS]; i_mdata_valid  input  [SIZE][REQUEST_CHANNELS]; i_mdata  input  [SIZE][REQUEST_CHANNELS][WRITE_DATA_WIDTH].
REQ-014 i_mresp_accept  input  [SIZE][RESPONSE_CHANNELS]; o_sresp_valid  output  [SIZE][RESPONSE_CHANNELS]; o_sresp  output  [SIZE][RESPONSE_CHANNELS][RESPONSE_WIDTH].

Function
REQ-015 SHALL instantiate one independent slice per (bus, channel, path); no slice shares state with another.
REQ-016 Mode 0: SHALL connect packed side to corebus_if combinationally (valid/payload forward, accept backward), zero latency, no state.
REQ-017 Mode 1: single register entry; upstream accept = entry empty; entry loads on valid&&accept; downstream valid = entry full; entry clears on downstream valid&&accept; SHALL NOT load and drain in the same cycle (max 1 beat / 2 cycles).
REQ-018 Mode 2: 2-entry FIFO; upstream accept = count<2; downstream valid = count>0; payload = head entry; simultaneous push and pop at count 1 or 2 SHALL keep count and preserve order; sustains 1 beat/cycle.
REQ-019 Modes 1 and 2: latency from upstream handshake to downstream valid SHALL be exactly 1 cycle; accept outputs SHALL depend only on registered state (no combinational valid->accept or accept->accept path).
REQ-020 Payload SHALL be transferred bit-exact; beat order per channel preserved; no beat dropped or duplicated.
REQ-021 Payload registers SHALL load only on push; payload held stable while downstream valid is high and not accepted.
REQ-022 Command/data slices SHALL drive corebus_if[i].mcmd_valid/mcmd/mdata_valid/mdata and observe scmd_accept/sdata_accept; response slices SHALL observe sresp_valid/sresp and drive mresp_accept.
REQ-023 Command and data paths of a channel SHALL be independent; no ordering enforced between them.
REQ-024 Full (count=2) with upstream valid high and no pop: accept SHALL be 0, state unchanged.
REQ-025 Empty with downstream accept high: no pop, count stays 0.
REQ-026 SHALL require corebus_if[0].REQUEST_CHANNELS == REQUEST_CHANNELS and RESPONSE_CHANNELS likewise (elaboration-time check).

Reset
REQ-027 While i_rst=1 all slice counts SHALL clear to 0 on the next edge; all o_*_accept, corebus_if mcmd_valid/mdata_valid, mresp_accept (sliced modes) and o_sresp_valid SHALL be 0 while i_rst=1.
REQ-028 First cycle after i_rst falls: sliced accepts SHALL be 1, all valids 0; payload registers need no reset.
REQ-029 Reset mid-transfer SHALL discard all buffered beats; no beat emitted after release.

Verification
REQ-030 SIZE=2, REQUEST_CHANNELS=2, mode 2, continuous cmd valid, slave accept=1 -> 1 beat/cycle per channel, first mcmd_valid 1 cycle after first handshake, payloads 0x1,0x2,0x3 in order.
REQ-031 Mode 2, slave scmd_accept=0 for 4 cycles with upstream valid -> exactly 2 beats buffered, o_scmd_accept=0 from cycle 2, release drains 2 beats in order.
REQ-032 Mode 1, continuous valid, accept=1 -> throughput 1 beat per 2 cycles, o_scmd_accept alternates 1,0.
REQ-033 Mode 0 -> corebus_if outputs equal inputs same cycle; o_sresp equals sresp same cycle.
REQ-034 Response path mode 2, i_mresp_accept toggled randomly 1000 cycles -> scoreboard matches all responses per channel, none lost.
REQ-035 i_rst asserted with 2 beats buffered -> next cycle all valids 0; after release accept=1, stale beats never appear.
